// File: rtl/sva_chk_pkg.sv
// Shared types and the latency-window legality macro for sva_window_checker.
`ifndef SVA_CHK_PKG_SV
`define SVA_CHK_PKG_SV

`define SVA_CHK_LAT_LEGAL(min_lat, max_lat) (((min_lat) >= 1) && ((max_lat) >= (min_lat)))

package sva_chk_pkg;

   // Storage width of a slot age; the top checks that its AGE_W fits here.
   localparam int THR_AGE_W = 8;

   typedef struct packed {
      logic                 active;
      logic [THR_AGE_W-1:0] age;
   } thread_info_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      SPAWN = 2'd2
   } ctrl_fsm_t;

   typedef enum logic [1:0] {
      RES_NONE = 2'd0,
      RES_SUCC = 2'd1,
      RES_FAIL = 2'd2,
      RES_KEEP = 2'd3
   } eval_res_t;

endpackage

`endif

// File: rtl/sva_thread_eval.sv
// Combinational next-state of one attempt slot for one user sample.
// SVA_EARLY_FAIL_EN: a consequent seen before MIN_LAT fails the attempt.
module sva_thread_eval
   import sva_chk_pkg::*;
#(
   parameter int MIN_LAT = 1,
   parameter int MAX_LAT = 8
) (
   input  thread_info_t cur,
   input  logic         b_s,
   output thread_info_t nxt,
   output eval_res_t    res
);

   localparam logic [THR_AGE_W-1:0] MIN_A = THR_AGE_W'(MIN_LAT);
   localparam logic [THR_AGE_W-1:0] MAX_A = THR_AGE_W'(MAX_LAT);

   logic [THR_AGE_W-1:0] a;

   always_comb begin
      a   = cur.age + THR_AGE_W'(1);
      nxt = cur;
      res = RES_NONE;
      if (cur.active) begin
         // Success is tested before the timeout so b at exactly MAX_LAT still passes.
         if (b_s && (a >= MIN_A) && (a <= MAX_A)) begin
            res = RES_SUCC;
            nxt = '0;
         end
`ifdef SVA_EARLY_FAIL_EN
         else if (b_s && (a < MIN_A)) begin
            res = RES_FAIL;
            nxt = '0;
         end
`endif
         else if (a == MAX_A) begin
            res = RES_FAIL;
            nxt = '0;
         end
         else begin
            res     = RES_KEEP;
            nxt.age = a;
         end
      end
   end

endmodule

// File: rtl/sva_window_checker.sv
// Multi-thread checker for "aw_valid |-> ##[MIN_LAT:MAX_LAT] b_valid" on sample strobes.
// SVA_EARLY_FAIL_EN selects the strict window in sva_thread_eval.
module sva_window_checker
   import sva_chk_pkg::*;
#(
   parameter int NUM_THREADS = 4,
   parameter int MIN_LAT     = 1,
   parameter int MAX_LAT     = 8,
   parameter int AGE_W       = $clog2(MAX_LAT + 1),
   parameter int CNT_W       = 16
) (
   input  logic                             sys_clk,
   input  logic                             sys_rst,
   input  logic                             sample_en,
   input  logic                             aw_valid,
   input  logic                             b_valid,
   input  logic                             clear_cnt,
   output logic                             busy,
   output logic                             succ,
   output logic                             fail,
   output logic                             overflow,
   output logic                             overrun,
   output logic [$clog2(NUM_THREADS+1)-1:0] active_cnt,
   output logic [CNT_W-1:0]                 succ_cnt,
   output logic [CNT_W-1:0]                 fail_cnt,
   output logic [CNT_W-1:0]                 ovf_cnt,
   output logic [1:0]                       fsm_state
);

   localparam int IDX_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
   localparam int ACT_W = $clog2(NUM_THREADS + 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_THREADS - 1);

   if (!(`SVA_CHK_LAT_LEGAL(MIN_LAT, MAX_LAT)) || (NUM_THREADS < 1) ||
       (AGE_W < $clog2(MAX_LAT + 1)) || (AGE_W > THR_AGE_W)) begin : g_bad_params
      $error("sva_window_checker: illegal NUM_THREADS/MIN_LAT/MAX_LAT/AGE_W");
   end

   ctrl_fsm_t    state_q, state_d;
   thread_info_t slot_q [NUM_THREADS];
   thread_info_t eval_nxt;
   eval_res_t    eval_res;
   logic         aw_s, b_s;
   logic [IDX_W-1:0] idx_q, free_idx_q;
   logic         free_found_q;
   logic [ACT_W-1:0] active_cnt_q;
   logic         succ_q, fail_q, ovf_q, overrun_q;
   logic         succ_d, fail_d, ovf_d;
   logic [CNT_W-1:0] succ_cnt_q, fail_cnt_q, ovf_cnt_q;

   sva_thread_eval #(
      .MIN_LAT (MIN_LAT),
      .MAX_LAT (MAX_LAT)
   ) u_eval (
      .cur (slot_q[idx_q]),
      .b_s (b_s),
      .nxt (eval_nxt),
      .res (eval_res)
   );

   // sample_en is a one-cycle strobe with no back-pressure: it is taken only in
   // IDLE, and a strobe seen while busy is dropped and flagged on overrun.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sample_en) state_d = SCAN;
         SCAN:    if (idx_q == LAST_IDX) state_d = SPAWN;
         SPAWN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign succ_d = (state_q == SCAN)  && (eval_res == RES_SUCC);
   assign fail_d = (state_q == SCAN)  && (eval_res == RES_FAIL);
   assign ovf_d  = (state_q == SPAWN) && aw_s && !free_found_q;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         for (int i = 0; i < NUM_THREADS; i++) slot_q[i] <= '0;
         aw_s         <= 1'b0;
         b_s          <= 1'b0;
         idx_q        <= '0;
         free_idx_q   <= '0;
         free_found_q <= 1'b0;
         active_cnt_q <= '0;
         succ_q       <= 1'b0;
         fail_q       <= 1'b0;
         ovf_q        <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         succ_q    <= succ_d;
         fail_q    <= fail_d;
         ovf_q     <= ovf_d;
         overrun_q <= sample_en && (state_q != IDLE);
         case (state_q)
            IDLE: begin
               if (sample_en) begin
                  aw_s         <= aw_valid;
                  b_s          <= b_valid;
                  idx_q        <= '0;
                  free_found_q <= 1'b0;
               end
            end
            SCAN: begin
               slot_q[idx_q] <= eval_nxt;
               if (succ_d || fail_d) active_cnt_q <= active_cnt_q - ACT_W'(1);
               // Slots freed this cycle count as free, so a retiring slot can be reused at once.
               if (!free_found_q && !eval_nxt.active) begin
                  free_found_q <= 1'b1;
                  free_idx_q   <= idx_q;
               end
               if (idx_q != LAST_IDX) idx_q <= idx_q + IDX_W'(1);
            end
            SPAWN: begin
               if (aw_s && free_found_q) begin
                  slot_q[free_idx_q] <= '{active: 1'b1, age: '0};
                  active_cnt_q       <= active_cnt_q + ACT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Saturating counters; clear wins over a same-cycle increment.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         succ_cnt_q <= '0;
         fail_cnt_q <= '0;
         ovf_cnt_q  <= '0;
      end else if (clear_cnt) begin
         succ_cnt_q <= '0;
         fail_cnt_q <= '0;
         ovf_cnt_q  <= '0;
      end else begin
         if (succ_d && (succ_cnt_q != '1)) succ_cnt_q <= succ_cnt_q + CNT_W'(1);
         if (fail_d && (fail_cnt_q != '1)) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
         if (ovf_d  && (ovf_cnt_q  != '1)) ovf_cnt_q  <= ovf_cnt_q  + CNT_W'(1);
      end
   end

   assign busy       = (state_q != IDLE);
   assign succ       = succ_q;
   assign fail       = fail_q;
   assign overflow   = ovf_q;
   assign overrun    = overrun_q;
   assign active_cnt = active_cnt_q;
   assign succ_cnt   = succ_cnt_q;
   assign fail_cnt   = fail_cnt_q;
   assign ovf_cnt    = ovf_cnt_q;
   assign fsm_state  = state_q;

endmodule

// File: tb/tb_sva_window_checker.sv
// Directed bench for sva_window_checker: event timing scoreboard plus counter checks.
module tb_sva_window_checker;

   localparam int NT    = 4;
   localparam int ACT_W = $clog2(NT + 1);
   localparam int CW    = 3;
   localparam int GAP   = NT + 2;
   localparam logic [31:0] EV_SUCC = 32'h1000_0000;
   localparam logic [31:0] EV_FAIL = 32'h2000_0000;
   localparam logic [31:0] EV_OVF  = 32'h3000_0000;
   localparam logic [31:0] EV_ORUN = 32'h4000_0000;

   // ---------------- clock / reset ----------------
   logic sys_clk   = 1'b0;
   logic sys_rst   = 1'b1;
   logic sample_en = 1'b0;
   logic aw_valid  = 1'b0;
   logic b_valid   = 1'b0;
   logic clear_cnt = 1'b0;
   int   cyc       = 0;

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   logic busy, succ, fail, overflow, overrun;
   logic [ACT_W-1:0] active_cnt;
   logic [CW-1:0]    succ_cnt, fail_cnt, ovf_cnt;
   logic [1:0]       fsm_state;

   logic busy2, succ2, fail2, overflow2, overrun2;
   logic [ACT_W-1:0] active_cnt2;
   logic [15:0]      succ_cnt2, fail_cnt2, ovf_cnt2;
   logic [1:0]       fsm_state2;

   sva_window_checker #(.NUM_THREADS(NT), .MIN_LAT(1), .MAX_LAT(8), .CNT_W(CW)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .sample_en(sample_en), .aw_valid(aw_valid),
      .b_valid(b_valid), .clear_cnt(clear_cnt), .busy(busy), .succ(succ), .fail(fail),
      .overflow(overflow), .overrun(overrun), .active_cnt(active_cnt), .succ_cnt(succ_cnt),
      .fail_cnt(fail_cnt), .ovf_cnt(ovf_cnt), .fsm_state(fsm_state)
   );

   sva_window_checker #(.NUM_THREADS(NT), .MIN_LAT(2), .MAX_LAT(8)) dut2 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .sample_en(sample_en), .aw_valid(aw_valid),
      .b_valid(b_valid), .clear_cnt(clear_cnt), .busy(busy2), .succ(succ2), .fail(fail2),
      .overflow(overflow2), .overrun(overrun2), .active_cnt(active_cnt2), .succ_cnt(succ_cnt2),
      .fail_cnt(fail_cnt2), .ovf_cnt(ovf_cnt2), .fsm_state(fsm_state2)
   );

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   logic [31:0] obs_q[$];
   logic [31:0] exp2_q[$];
   logic [31:0] obs2_q[$];
   int n_checks = 0;
   int n_errors = 0;
   int samp_t[32];

   always @(negedge sys_clk) begin
      if (!sys_rst) begin
         if (succ)      obs_q.push_back(EV_SUCC | 32'(cyc));
         if (fail)      obs_q.push_back(EV_FAIL | 32'(cyc));
         if (overflow)  obs_q.push_back(EV_OVF  | 32'(cyc));
         if (overrun)   obs_q.push_back(EV_ORUN | 32'(cyc));
         if (succ2)     obs2_q.push_back(EV_SUCC | 32'(cyc));
         if (fail2)     obs2_q.push_back(EV_FAIL | 32'(cyc));
         if (overflow2) obs2_q.push_back(EV_OVF  | 32'(cyc));
         if (overrun2)  obs2_q.push_back(EV_ORUN | 32'(cyc));
      end
   end

   function automatic logic [31:0] ev(input logic [31:0] kind, input int c);
      return kind | 32'(c);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_events(input string tag, input logic [31:0] obs[$],
                                 input logic [31:0] exp[$]);
      check({tag, "_nevents"}, 32'(obs.size()), 32'(exp.size()));
      for (int i = 0; (i < obs.size()) && (i < exp.size()); i++)
         check({tag, "_event"}, obs[i], exp[i]);
   endtask

   // ---------------- driver tasks ----------------
   task automatic do_sample(input logic aw, input logic b, input int gap, output int t);
      sample_en = 1'b1;
      aw_valid  = aw;
      b_valid   = b;
      t         = cyc;
      @(negedge sys_clk);
      sample_en = 1'b0;
      aw_valid  = 1'b0;
      b_valid   = 1'b0;
      repeat (gap - 1) @(negedge sys_clk);
   endtask

   task automatic run_seq(input logic [31:0] aw_v, input logic [31:0] b_v,
                          input int first, input int n, input int gap);
      int tt;
      for (int k = first; k < first + n; k++) begin
         do_sample(aw_v[k], b_v[k], gap, tt);
         samp_t[k] = tt;
      end
   endtask

   task automatic apply_reset();
      repeat ($urandom_range(0, 3)) @(negedge sys_clk);
      sys_rst = 1'b1;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      @(negedge sys_clk);
      obs_q.delete();
      obs2_q.delete();
      exp_q.delete();
      exp2_q.delete();
   endtask

   task automatic settle_and_compare(input string tag);
      repeat (12) @(negedge sys_clk);
      compare_events(tag, obs_q, exp_q);
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
      $fatal(1, "watchdog");
   end

   int d_tab[3] = '{1, 3, 8};
   int t_clr;

   initial begin
      // Reset state of both instances
      @(negedge sys_clk);
      check("rst_flags", 32'({busy, succ, fail, overflow, overrun, fsm_state}), 32'd0);
      check("rst_cnts", 32'({active_cnt, succ_cnt, fail_cnt, ovf_cnt}), 32'd0);
      check("rst2_flags", 32'({busy2, succ2, fail2, overflow2, overrun2, fsm_state2, active_cnt2}), 32'd0);
      check("rst2_cnts", 32'(succ_cnt2 | fail_cnt2 | ovf_cnt2), 32'd0);

      // A: single attempt, b at distance d (window edges and middle)
      foreach (d_tab[j]) begin
         apply_reset();
         run_seq(32'h1, 32'h1 << d_tab[j], 0, d_tab[j] + 1, GAP);
         exp_q.push_back(ev(EV_SUCC, samp_t[d_tab[j]] + 2));
         settle_and_compare("tA");
         check("tA_succ_cnt", 32'(succ_cnt), 32'd1);
         check("tA_fail_cnt", 32'(fail_cnt), 32'd0);
         check("tA_active", 32'(active_cnt), 32'd0);
      end

      // B: no consequent -> timeout in the sample-8 scan
      apply_reset();
      run_seq(32'h1, 32'h0, 0, 1, GAP);
      check("tB_active1", 32'(active_cnt), 32'd1);
      run_seq(32'h1, 32'h0, 1, 8, GAP);
      exp_q.push_back(ev(EV_FAIL, samp_t[8] + 2));
      settle_and_compare("tB");
      check("tB_fail_cnt", 32'(fail_cnt), 32'd1);
      check("tB_succ_cnt", 32'(succ_cnt), 32'd0);

      // C: three overlapping attempts all satisfied by one b
      apply_reset();
      run_seq(32'h7, 32'h8, 0, 4, GAP);
      for (int i = 0; i < 3; i++) exp_q.push_back(ev(EV_SUCC, samp_t[3] + 2 + i));
      settle_and_compare("tC");
      check("tC_succ_cnt", 32'(succ_cnt), 32'd3);
      check("tC_active", 32'(active_cnt), 32'd0);

      // D: pool exhaustion, then staggered timeouts
      apply_reset();
      run_seq(32'h1F, 32'h0, 0, 5, GAP);
      check("tD_active4", 32'(active_cnt), 32'd4);
      check("tD_ovf_cnt", 32'(ovf_cnt), 32'd1);
      run_seq(32'h0, 32'h0, 5, 7, GAP);
      exp_q.push_back(ev(EV_OVF, samp_t[4] + 2 + NT));
      for (int i = 0; i < 4; i++) exp_q.push_back(ev(EV_FAIL, samp_t[8 + i] + 2 + i));
      settle_and_compare("tD");
      check("tD_fail_cnt", 32'(fail_cnt), 32'd4);
      check("tD_active0", 32'(active_cnt), 32'd0);
      check("tD_ovf_cnt_end", 32'(ovf_cnt), 32'd1);

      // E: strobes 3 cycles apart; dropped samples carry b=1 and must not age slots
      apply_reset();
      run_seq(32'h1, 32'hA, 0, 5, 3);
      repeat (4) @(negedge sys_clk);
      check("tE_active", 32'(active_cnt), 32'd1);
      check("tE_succ_cnt", 32'(succ_cnt), 32'd0);
      run_seq(32'h0, 32'h0, 5, 6, GAP);
      exp_q.push_back(ev(EV_ORUN, samp_t[1] + 1));
      exp_q.push_back(ev(EV_ORUN, samp_t[3] + 1));
      exp_q.push_back(ev(EV_FAIL, samp_t[10] + 2));
      settle_and_compare("tE");
      check("tE_fail_cnt", 32'(fail_cnt), 32'd1);

      // F: reset asserted during SCAN discards in-flight attempts
      apply_reset();
      run_seq(32'h3, 32'h0, 0, 2, GAP);
      check("tF_active_pre", 32'(active_cnt), 32'd2);
      sample_en = 1'b1; aw_valid = 1'b1; b_valid = 1'b1;
      @(negedge sys_clk);
      sample_en = 1'b0; aw_valid = 1'b0; b_valid = 1'b0;
      check("tF_busy_scan", 32'(busy), 32'd1);
      sys_rst = 1'b1;
      #1;
      check("tF_rst_flags", 32'({busy, succ, fail, overflow, overrun, fsm_state}), 32'd0);
      check("tF_rst_cnts", 32'({active_cnt, succ_cnt, fail_cnt, ovf_cnt}), 32'd0);
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      settle_and_compare("tF");
      check("tF_active_post", 32'(active_cnt), 32'd0);
      check("tF_succ_cnt", 32'(succ_cnt), 32'd0);

      // G: counter saturation, then clear colliding with an increment
      apply_reset();
      run_seq(32'h3FF, 32'h3FE, 0, 10, GAP);
      for (int k = 1; k < 10; k++) exp_q.push_back(ev(EV_SUCC, samp_t[k] + 2));
      check("tG_sat", 32'(succ_cnt), 32'd7);
      check("tG_active", 32'(active_cnt), 32'd1);
      sample_en = 1'b1; b_valid = 1'b1; t_clr = cyc;
      @(negedge sys_clk);
      sample_en = 1'b0; b_valid = 1'b0; clear_cnt = 1'b1;
      @(negedge sys_clk);
      clear_cnt = 1'b0;
      exp_q.push_back(ev(EV_SUCC, t_clr + 2));
      check("tG_clr_pulse", 32'(succ), 32'd1);
      check("tG_clr_cnt", 32'(succ_cnt), 32'd0);
      settle_and_compare("tG");
      check("tG_cnt_after", 32'(succ_cnt), 32'd0);
      check("tG_active0", 32'(active_cnt), 32'd0);

      // H: MIN_LAT=2 instance with an early b
      apply_reset();
      run_seq(32'h1, 32'h6, 0, 3, GAP);
      exp_q.push_back(ev(EV_SUCC, samp_t[1] + 2));
`ifdef SVA_EARLY_FAIL_EN
      exp2_q.push_back(ev(EV_FAIL, samp_t[1] + 2));
`else
      exp2_q.push_back(ev(EV_SUCC, samp_t[2] + 2));
`endif
      repeat (12) @(negedge sys_clk);
      compare_events("tH2", obs2_q, exp2_q);
      compare_events("tH", obs_q, exp_q);
      check("tH2_active", 32'(active_cnt2), 32'd0);
      check("tH2_results", 32'(succ_cnt2 + fail_cnt2), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
